// File: rtl/hex_display_ctrl.sv
// Rate-limited, registered seven-segment controller for a bank of NUM_DIGITS hex digits.
// Per-digit blinking is built only when HEX_DISPLAY_BLINK_EN is defined.
module hex_display_ctrl #(
  parameter int NUM_DIGITS = 6,
  parameter int UPDATE_DIV = 5_000_000,
  parameter int BLINK_DIV  = 12_500_000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    value_valid,
  output logic                    value_ready,
  input  logic [1:0]              mode,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [7*NUM_DIGITS-1:0] hex_out,
  output logic                    update_pulse
);

  localparam logic [1:0] MODE_HEX    = 2'b00;
  localparam logic [1:0] MODE_LZB    = 2'b01;
  localparam logic [1:0] MODE_FREEZE = 2'b10;
  localparam logic [1:0] MODE_BLANK  = 2'b11;

  localparam int UPD_W = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
  localparam logic [UPD_W-1:0] UPD_LAST = UPD_W'(UPDATE_DIV - 1);

  logic [UPD_W-1:0]        upd_cnt_reg, upd_cnt_next;
  logic [4*NUM_DIGITS-1:0] pending_reg, pending_next;
  logic                    pending_flag_reg, pending_flag_next;
  logic [4*NUM_DIGITS-1:0] display_reg, display_next;
  logic                    update_pulse_reg, update_pulse_next;
  logic [7*NUM_DIGITS-1:0] hex_out_reg, hex_out_next;

  logic                    tick;
  logic                    accept;
  logic                    frozen;
  logic                    blink_phase;
  logic [NUM_DIGITS-1:0]   blink_active;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic [NUM_DIGITS:1]     zero_from;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      4'hF: seg7 = 7'h0E;
    endcase
  endfunction

  assign frozen       = (mode == MODE_FREEZE);
  assign value_ready  = !frozen;
  assign accept       = value_valid && value_ready;
  assign tick         = (upd_cnt_reg == UPD_LAST);
  assign update_pulse = update_pulse_reg;
  assign hex_out      = hex_out_reg;

  // Refresh counter and load path. A same-edge accept bypasses pending_reg.
  always_comb begin
    upd_cnt_next      = tick ? '0 : upd_cnt_reg + 1'b1;
    pending_next      = pending_reg;
    pending_flag_next = pending_flag_reg;
    display_next      = display_reg;
    update_pulse_next = 1'b0;
    if (accept) begin
      pending_next      = value;
      pending_flag_next = 1'b1;
    end
    if (tick && !frozen) begin
      if (accept) begin
        display_next      = value;
        pending_flag_next = 1'b0;
        update_pulse_next = 1'b1;
      end else if (pending_flag_reg) begin
        display_next      = pending_reg;
        pending_flag_next = 1'b0;
        update_pulse_next = 1'b1;
      end
    end
  end

`ifdef HEX_DISPLAY_BLINK_EN
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  logic [BLK_W-1:0] blink_cnt_reg;
  logic             blink_phase_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
    end else if (blink_cnt_reg == BLK_LAST) begin
      blink_cnt_reg   <= '0;
      blink_phase_reg <= ~blink_phase_reg;
    end else begin
      blink_cnt_reg   <= blink_cnt_reg + 1'b1;
    end
  end

  assign blink_phase = blink_phase_reg;
`else
  logic blink_div_unused;
  assign blink_div_unused = (BLINK_DIV < 1);
  assign blink_phase      = 1'b0;
`endif

  assign blink_active = blink_mask & {NUM_DIGITS{blink_phase}};

  // zero_from[k]: every digit from k upward is zero, so digit k is a leading zero.
  assign zero_from[NUM_DIGITS] = 1'b1;
  assign lz_blank[0]           = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_DIGITS; gi++) begin : g_lz
      assign zero_from[gi] = zero_from[gi+1] && (display_reg[4*gi +: 4] == 4'h0);
      assign lz_blank[gi]  = zero_from[gi];
    end

    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic blank;
      assign blank = (mode == MODE_BLANK)
                  || ((mode == MODE_LZB) && lz_blank[gi])
                  || blink_active[gi];
      assign hex_out_next[7*gi +: 7] = blank ? 7'h7F : seg7(display_reg[4*gi +: 4]);
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      upd_cnt_reg      <= '0;
      pending_reg      <= '0;
      pending_flag_reg <= 1'b0;
      display_reg      <= '0;
      update_pulse_reg <= 1'b0;
      hex_out_reg      <= {NUM_DIGITS{7'h7F}};
    end else begin
      upd_cnt_reg      <= upd_cnt_next;
      pending_reg      <= pending_next;
      pending_flag_reg <= pending_flag_next;
      display_reg      <= display_next;
      update_pulse_reg <= update_pulse_next;
      hex_out_reg      <= hex_out_next;
    end
  end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Scoreboard bench for hex_display_ctrl: expected display images are queued when a value
// is driven and popped when the controller reports an update.
module tb_hex_display_ctrl;

  localparam int N  = 6;
  localparam int UD = 4;
  localparam int BD = 3;
`ifdef HEX_DISPLAY_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [4*N-1:0] value = '0;
  logic          value_valid = 1'b0;
  logic          value_ready;
  logic [1:0]    mode = 2'b00;
  logic [N-1:0]  blink_mask = '0;
  logic [7*N-1:0] hex_out;
  logic          update_pulse;

  int pass_cnt = 0;
  int check_cnt = 0;
  int edge_cnt;
  logic [7*N-1:0] exp_q[$];
  logic [7*N-1:0] all_blank;
  logic [7*N-1:0] exp_img;

  always #5 clk = ~clk;

  hex_display_ctrl #(
    .NUM_DIGITS(N),
    .UPDATE_DIV(UD),
    .BLINK_DIV (BD)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .value       (value),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .mode        (mode),
    .blink_mask  (blink_mask),
    .hex_out     (hex_out),
    .update_pulse(update_pulse)
  );

  // Edges since reset release; refresh ticks fall on multiples of UD.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) edge_cnt <= 0;
    else          edge_cnt <= edge_cnt + 1;
  end

  function automatic logic [7*N-1:0] image(input logic [4*N-1:0] v, input logic [1:0] m,
                                           input logic [N-1:0] off);
    logic [7*N-1:0] img;
    logic [6:0] s;
    img = '0;
    for (int d = 0; d < N; d++) begin
      s = SEG[v[4*d +: 4]];
      if (m == 2'b11) s = 7'h7F;
      if (m == 2'b01 && d > 0 && (v >> (4*d)) == '0) s = 7'h7F;
      if (off[d]) s = 7'h7F;
      img[7*d +: 7] = s;
    end
    return img;
  endfunction

  task automatic align_window();
    for (int i = 0; i < UD + 1; i++) begin
      if (edge_cnt % UD == 0) break;
      @(negedge clk);
    end
  endtask

  task automatic wait_update(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 4*UD && !seen; i++) begin
      @(negedge clk);
      if (update_pulse === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic load(input logic [4*N-1:0] v);
    align_window();
    value = v;
    value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
  endtask

  task automatic test_reset();
    all_blank = {N{7'h7F}};
    reset_n = 1'b0;
    mode = 2'b00;
    #12;
    check_cnt++;
    if (hex_out !== all_blank) $display("FAIL reset_hex got=%h want=%h", hex_out, all_blank);
    else pass_cnt++;
    check_cnt++;
    if (update_pulse !== 1'b0) $display("FAIL reset_pulse got=%b want=0", update_pulse);
    else pass_cnt++;
    check_cnt++;
    if (value_ready !== 1'b1) $display("FAIL reset_ready got=%b want=1", value_ready);
    else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    exp_img = image('0, 2'b00, '0);
    check_cnt++;
    if (hex_out !== exp_img) $display("FAIL first_edge_hex got=%h want=%h", hex_out, exp_img);
    else pass_cnt++;
    $display("reset: hex_out=%h", hex_out);
  endtask

  task automatic test_basic_load();
    bit seen;
    load(24'h12AB3F);
    exp_q.push_back(image(24'h12AB3F, 2'b00, '0));
    wait_update(seen);
    check_cnt++;
    if (!seen) $display("FAIL basic_pulse timeout got=0 want=1");
    else pass_cnt++;
    check_cnt++;
    if (edge_cnt % UD != 0) $display("FAIL basic_tick_edge got=%0d want=0", edge_cnt % UD);
    else pass_cnt++;
    @(negedge clk);
    exp_img = exp_q.pop_front();
    check_cnt++;
    if (hex_out !== exp_img) $display("FAIL basic_hex got=%h want=%h", hex_out, exp_img);
    else pass_cnt++;
    check_cnt++;
    if (update_pulse !== 1'b0) $display("FAIL basic_pulse_width got=%b want=0", update_pulse);
    else pass_cnt++;
    $display("basic_load: value=12ab3f hex_out=%h", hex_out);
  endtask

  task automatic test_last_wins();
    bit seen;
    int extra;
    align_window();
    value = 24'h000001;
    value_valid = 1'b1;
    @(negedge clk);
    value = 24'h000002;
    @(negedge clk);
    value_valid = 1'b0;
    exp_q.push_back(image(24'h000002, 2'b00, '0));
    wait_update(seen);
    check_cnt++;
    if (!seen) $display("FAIL lastwins_pulse timeout got=0 want=1");
    else pass_cnt++;
    @(negedge clk);
    exp_img = exp_q.pop_front();
    check_cnt++;
    if (hex_out !== exp_img) $display("FAIL lastwins_hex got=%h want=%h", hex_out, exp_img);
    else pass_cnt++;
    extra = 0;
    for (int i = 0; i < 2*UD; i++) begin
      @(negedge clk);
      if (update_pulse === 1'b1) extra++;
    end
    check_cnt++;
    if (extra != 0) $display("FAIL lastwins_extra_pulses got=%0d want=0", extra);
    else pass_cnt++;
    $display("last_wins: hex_out=%h extra_pulses=%0d", hex_out, extra);
  endtask

  task automatic test_bypass();
    align_window();
    for (int i = 0; i < UD - 1; i++) @(negedge clk);
    value = 24'h0000C0;
    value_valid = 1'b1;
    exp_q.push_back(image(24'h0000C0, 2'b00, '0));
    @(negedge clk);
    value_valid = 1'b0;
    check_cnt++;
    if (update_pulse !== 1'b1) $display("FAIL bypass_pulse got=%b want=1", update_pulse);
    else pass_cnt++;
    @(negedge clk);
    exp_img = exp_q.pop_front();
    check_cnt++;
    if (hex_out !== exp_img) $display("FAIL bypass_hex got=%h want=%h", hex_out, exp_img);
    else pass_cnt++;
    $display("bypass: value=0000c0 hex_out=%h", hex_out);
  endtask

  task automatic test_lzb();
    bit seen;
    logic [4*N-1:0] vals [2];
    vals[0] = 24'h000A00;
    vals[1] = 24'h000000;
    mode = 2'b01;
    for (int k = 0; k < 2; k++) begin
      load(vals[k]);
      exp_q.push_back(image(vals[k], 2'b01, '0));
      wait_update(seen);
      check_cnt++;
      if (!seen) $display("FAIL lzb_pulse timeout got=0 want=1 value=%h", vals[k]);
      else pass_cnt++;
      @(negedge clk);
      exp_img = exp_q.pop_front();
      check_cnt++;
      if (hex_out !== exp_img) $display("FAIL lzb_hex value=%h got=%h want=%h", vals[k], hex_out, exp_img);
      else pass_cnt++;
      $display("lzb: value=%h hex_out=%h", vals[k], hex_out);
    end
    mode = 2'b00;
  endtask

  task automatic test_freeze();
    bit seen;
    int pulses;
    align_window();
    value = 24'h000005;
    value_valid = 1'b1;
    @(negedge clk);
    mode = 2'b10;
    value = 24'h000009;
    #1;
    check_cnt++;
    if (value_ready !== 1'b0) $display("FAIL freeze_ready got=%b want=0", value_ready);
    else pass_cnt++;
    pulses = 0;
    for (int i = 0; i < 3*UD; i++) begin
      @(negedge clk);
      if (update_pulse === 1'b1) pulses++;
    end
    check_cnt++;
    if (pulses != 0) $display("FAIL freeze_pulses got=%0d want=0", pulses);
    else pass_cnt++;
    mode = 2'b00;
    value_valid = 1'b0;
    exp_q.push_back(image(24'h000005, 2'b00, '0));
    wait_update(seen);
    check_cnt++;
    if (!seen) $display("FAIL unfreeze_pulse timeout got=0 want=1");
    else pass_cnt++;
    @(negedge clk);
    exp_img = exp_q.pop_front();
    check_cnt++;
    if (hex_out !== exp_img) $display("FAIL unfreeze_hex got=%h want=%h", hex_out, exp_img);
    else pass_cnt++;
    $display("freeze: pulses=%0d hex_out_after=%h", pulses, hex_out);
  endtask

  task automatic test_blink();
    bit seen;
    bit phase;
    load(24'h000007);
    wait_update(seen);
    check_cnt++;
    if (!seen) $display("FAIL blink_load_pulse timeout got=0 want=1");
    else pass_cnt++;
    blink_mask = 6'b000001;
    for (int i = 0; i < 4*BD; i++) begin
      @(negedge clk);
      phase = (((edge_cnt - 1) / BD) % 2) == 1;
      exp_img = image(24'h000007, 2'b00, (BLINK_EN && phase) ? 6'b000001 : 6'b000000);
      check_cnt++;
      if (hex_out !== exp_img) $display("FAIL blink_hex edge=%0d got=%h want=%h", edge_cnt, hex_out, exp_img);
      else pass_cnt++;
      $display("blink: edge=%0d hex_out=%h", edge_cnt, hex_out);
    end
    blink_mask = '0;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    int pulses;
    align_window();
    value = 24'h000033;
    value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check_cnt++;
    if (hex_out !== all_blank) $display("FAIL midreset_hex got=%h want=%h", hex_out, all_blank);
    else pass_cnt++;
    check_cnt++;
    if (update_pulse !== 1'b0) $display("FAIL midreset_pulse got=%b want=0", update_pulse);
    else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 3*UD; i++) begin
      @(negedge clk);
      if (update_pulse === 1'b1) pulses++;
    end
    check_cnt++;
    if (pulses != 0) $display("FAIL midreset_pending_lost got=%0d want=0", pulses);
    else pass_cnt++;
    exp_img = image('0, 2'b00, '0);
    check_cnt++;
    if (hex_out !== exp_img) $display("FAIL midreset_hex_after got=%h want=%h", hex_out, exp_img);
    else pass_cnt++;
    $display("async_reset: pulses_after=%0d hex_out=%h", pulses, hex_out);
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_last_wins();
    test_bypass();
    test_lzb();
    test_freeze();
    test_blink();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
